// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the push-button conditioner
package btn_pkg;

  // Per-channel debounce state: settled low, rising candidate, settled high, falling candidate
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } btn_state_t;

  // 10 ms of stable input at a 100 MHz clock
  localparam int DEBOUNCE_100MHZ = 1000000;

  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - raw button pins in, conditioned level and edge pulses out
interface btn_conditioner_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  // Front panel / stimulus side: drives the pins, consumes the conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, stable-time counter, FSM, registered outputs
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [CNT_W-1:0]       cnt;
  btn_state_t             state;

  // Plain flop chain bringing the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Debounce FSM; any disagreement during a candidate phase throws the count away,
  // so stable time is never accumulated across glitches
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= S_LOW;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      case (state)
        S_LOW: begin
          if (btn_sync) begin
            cnt   <= CNT_ONE;
            state <= S_RISE;
          end
        end
        S_RISE: begin
          if (!btn_sync) begin
            cnt   <= '0;
            state <= S_LOW;
          end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= S_HIGH;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            // cnt < CNT_MAX here, so the increment can never wrap
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!btn_sync) begin
            cnt   <= CNT_ONE;
            state <= S_FALL;
          end
        end
        S_FALL: begin
          if (btn_sync) begin
            cnt   <= '0;
            state <= S_HIGH;
          end else if (cnt == CNT_MAX) begin
            cnt      <= '0;
            state    <= S_LOW;
            level    <= 1'b0;
            released <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_LOW;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N independent debounced button channels for the reaction-timer panel
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ
) (
  input  logic              clk,
  input  logic              clear,
  btn_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;

  // One fully independent channel per button; no counter is shared
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .clear    (clear),
      .raw      (bus.btn_raw[i]),
      .level    (level_w[i]),
      .press    (press_w[i]),
      .released (release_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed scoreboard bench for btn_conditioner
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N   = 2;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAT = 1 + SS + DC;  // negedge after the sampling edge, counted from the driving negedge

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] level;
  } ev_t;

  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  evq[$];
  logic [N-1:0] steady_level = '0;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] l);
    ev_t e;
    e.cyc = cyc + LAT; e.press = p; e.rel = r; e.level = l;
    evq.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle either matches the scheduled event or shows quiet outputs
  always @(negedge clk) begin
    if (!clear) begin
      check("press_and_release_exclusive", bus.btn_press & bus.btn_release, '0);
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
        ev_t e;
        e = evq.pop_front();
        check("event_press", bus.btn_press, e.press);
        check("event_release", bus.btn_release, e.rel);
        check("event_level", bus.btn_level, e.level);
        steady_level = e.level;
      end else begin
        check("quiet_press", bus.btn_press, '0);
        check("quiet_release", bus.btn_release, '0);
        check("quiet_level", bus.btn_level, steady_level);
      end
    end
  end

  initial begin
    clear = 1'b1;
    bus.btn_raw = '0;
    wait_n(2);
    check("reset_level", bus.btn_level, '0);
    check("reset_press", bus.btn_press, '0);
    check("reset_release", bus.btn_release, '0);
    clear = 1'b0;
    wait_n(3);

    // Clean press on channel 0
    bus.btn_raw = 2'b01; push(2'b01, 2'b00, 2'b01);
    wait_n(10);
    check("held_level", bus.btn_level, 2'b01);

    // Clean release
    bus.btn_raw = 2'b00; push(2'b00, 2'b01, 2'b00);
    wait_n(10);

    // Bounce: 3 high, 1 low, then held
    bus.btn_raw = 2'b01; wait_n(3);
    bus.btn_raw = 2'b00; wait_n(1);
    bus.btn_raw = 2'b01; push(2'b01, 2'b00, 2'b01);
    wait_n(10);

    // 2-cycle low glitch while held: no release
    bus.btn_raw = 2'b00; wait_n(2);
    bus.btn_raw = 2'b01; wait_n(10);
    check("glitch_held_level", bus.btn_level, 2'b01);

    bus.btn_raw = 2'b00; push(2'b00, 2'b01, 2'b00);
    wait_n(10);

    // Both channels on the same edge
    bus.btn_raw = 2'b11; push(2'b11, 2'b00, 2'b11);
    wait_n(10);
    bus.btn_raw = 2'b00; push(2'b00, 2'b11, 2'b00);
    wait_n(10);

    // Channel 1 staggered by 2 cycles
    bus.btn_raw = 2'b01; push(2'b01, 2'b00, 2'b01);
    wait_n(2);
    bus.btn_raw = 2'b11; push(2'b10, 2'b00, 2'b11);
    wait_n(10);
    bus.btn_raw = 2'b00; push(2'b00, 2'b11, 2'b00);
    wait_n(10);

    // Reset mid-count with channel 1 held through it
    bus.btn_raw = 2'b10;
    wait_n(3);
    clear = 1'b1;
    steady_level = '0;
    #1;
    check("clear_async_level", bus.btn_level, '0);
    check("clear_async_press", bus.btn_press, '0);
    wait_n(1);
    check("clear_level", bus.btn_level, '0);
    check("clear_press", bus.btn_press, '0);
    check("clear_release", bus.btn_release, '0);
    wait_n(1);
    check("clear_level2", bus.btn_level, '0);
    check("clear_press2", bus.btn_press, '0);
    clear = 1'b0;
    push(2'b10, 2'b00, 2'b10);
    wait_n(12);
    check("post_reset_level", bus.btn_level, 2'b10);

    n_assert++;
    assert (evq.size() == 0) else begin
      n_fail++;
      $error("FAIL events_outstanding: observed %0d expected 0", evq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
